// File: rtl/gam_node_memory_if.sv
// Request, allocation and response bundle between the GAM learning controller
// and the node store; the controller drives the master side.
interface gam_node_memory_if #(
  parameter int NUM_CLASSES     = 8,
  parameter int NODES_PER_CLASS = 16,
  parameter int VEC_LEN         = 4,
  parameter int ELEM_W          = 16,
  parameter int SCALAR_W        = 32
);
  localparam int CW = $clog2(NUM_CLASSES);
  localparam int NW = $clog2(NODES_PER_CLASS);
  localparam int KW = $clog2(NODES_PER_CLASS + 1);
  localparam int VW = VEC_LEN * ELEM_W;

  logic                      req_valid;
  logic                      req_ready;
  logic [1:0]                req_op;
  logic [CW-1:0]             req_class;
  logic [NW-1:0]             req_node;
  logic [3:0]                req_fen;
  logic [VW-1:0]             req_x;
  logic [VW-1:0]             req_w;
  logic [SCALAR_W-1:0]       req_th;
  logic [SCALAR_W-1:0]       req_m;
  logic                      alloc_valid;
  logic [CW-1:0]             alloc_class;
  logic                      alloc_done;
  logic                      alloc_ok;
  logic [NW-1:0]             alloc_node;
  logic                      rsp_valid;
  logic                      rsp_err;
  logic [VW-1:0]             rsp_x;
  logic [VW-1:0]             rsp_w;
  logic [SCALAR_W-1:0]       rsp_th;
  logic [SCALAR_W-1:0]       rsp_m;
  logic [NUM_CLASSES*KW-1:0] node_count;

  modport master (
    output req_valid, req_op, req_class, req_node, req_fen, req_x, req_w, req_th, req_m,
           alloc_valid, alloc_class,
    input  req_ready, alloc_done, alloc_ok, alloc_node,
           rsp_valid, rsp_err, rsp_x, rsp_w, rsp_th, rsp_m, node_count
  );

  modport slave (
    input  req_valid, req_op, req_class, req_node, req_fen, req_x, req_w, req_th, req_m,
           alloc_valid, alloc_class,
    output req_ready, alloc_done, alloc_ok, alloc_node,
           rsp_valid, rsp_err, rsp_x, rsp_w, rsp_th, rsp_m, node_count
  );
endinterface

// File: rtl/gam_node_memory.sv
// GAM node store: per-class X/W/Th/M slots with dense allocation, saturating
// M increment, flash class clear and a post-reset zeroing sweep.
module gam_node_memory #(
  parameter int NUM_CLASSES     = 8,
  parameter int NODES_PER_CLASS = 16,
  parameter int VEC_LEN         = 4,
  parameter int ELEM_W          = 16,
  parameter int SCALAR_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  gam_node_memory_if.slave bus
);
  localparam int NW      = $clog2(NODES_PER_CLASS);
  localparam int KW      = $clog2(NODES_PER_CLASS + 1);
  localparam int VW      = VEC_LEN * ELEM_W;
  localparam int ENTRIES = NUM_CLASSES * NODES_PER_CLASS;
  localparam int AW      = $clog2(ENTRIES);
  localparam logic [SCALAR_W-1:0] M_MAX = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_INC_M, OP_CLEAR} op_t;

  state_t              state, next_state;
  logic [AW-1:0]       sweep_idx;
  logic                sweep_last;
  logic [KW-1:0]       count [NUM_CLASSES];
  logic [VW-1:0]       x_mem [ENTRIES];
  logic [VW-1:0]       w_mem [ENTRIES];
  logic [SCALAR_W-1:0] th_mem[ENTRIES];
  logic [SCALAR_W-1:0] m_mem [ENTRIES];

  op_t                 op;
  logic                accept, node_ok, alloc_go, clear_hit;
  logic [AW-1:0]       addr;
  logic [SCALAR_W-1:0] m_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= next_state;
  end

  // NOTE: every signal driven in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    next_state = state;
    sweep_last = (sweep_idx == AW'(ENTRIES - 1));
    if (state == S_INIT && sweep_last) next_state = S_RUN;
  end

  assign bus.req_ready = (state == S_RUN);
  assign op        = op_t'(bus.req_op);
  assign accept    = bus.req_valid && bus.req_ready;
  // Slots fill densely from 0, so a node is live exactly when it is below the class count.
  assign node_ok   = (int'(bus.req_class) < NUM_CLASSES) &&
                     (KW'(bus.req_node) < count[bus.req_class]);
  assign addr      = AW'(int'(bus.req_class) * NODES_PER_CLASS + int'(bus.req_node));
  assign m_inc     = (m_mem[addr] == M_MAX) ? M_MAX : m_mem[addr] + 1'b1;
  assign alloc_go  = (state == S_RUN) && bus.alloc_valid &&
                     (int'(bus.alloc_class) < NUM_CLASSES);
  assign clear_hit = accept && (op == OP_CLEAR) && (bus.req_class == bus.alloc_class);

  // NOTE: the node arrays have no reset; the INIT sweep zeroes them so they can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      x_mem[sweep_idx]  <= '0;
      w_mem[sweep_idx]  <= '0;
      th_mem[sweep_idx] <= '0;
      m_mem[sweep_idx]  <= '0;
    end else if (accept && node_ok) begin
      if (op == OP_WRITE) begin
        if (bus.req_fen[0]) x_mem[addr]  <= bus.req_x;
        if (bus.req_fen[1]) w_mem[addr]  <= bus.req_w;
        if (bus.req_fen[2]) th_mem[addr] <= bus.req_th;
        if (bus.req_fen[3]) m_mem[addr]  <= bus.req_m;
      end else if (op == OP_INC_M) begin
        m_mem[addr] <= m_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_idx      <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) count[c] <= '0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_err    <= 1'b0;
      bus.rsp_x      <= '0;
      bus.rsp_w      <= '0;
      bus.rsp_th     <= '0;
      bus.rsp_m      <= '0;
      bus.alloc_done <= 1'b0;
      bus.alloc_ok   <= 1'b0;
      bus.alloc_node <= '0;
    end else begin
      if (state == S_INIT && !sweep_last) sweep_idx <= sweep_idx + 1'b1;

      bus.rsp_valid <= accept;
      if (accept) begin
        bus.rsp_err <= (op != OP_CLEAR) && !node_ok;
        bus.rsp_x   <= '0;
        bus.rsp_w   <= '0;
        bus.rsp_th  <= '0;
        bus.rsp_m   <= '0;
        if (node_ok && op == OP_READ) begin
          bus.rsp_x  <= x_mem[addr];
          bus.rsp_w  <= w_mem[addr];
          bus.rsp_th <= th_mem[addr];
          bus.rsp_m  <= m_mem[addr];
        end else if (node_ok && op == OP_INC_M) begin
          bus.rsp_m  <= m_inc;
        end
      end

      bus.alloc_done <= alloc_go;
      if (alloc_go) begin
        if (clear_hit) begin
          bus.alloc_ok   <= 1'b0;
          bus.alloc_node <= '0;
        end else if (count[bus.alloc_class] < KW'(NODES_PER_CLASS)) begin
          bus.alloc_ok             <= 1'b1;
          bus.alloc_node           <= NW'(count[bus.alloc_class]);
          count[bus.alloc_class]   <= count[bus.alloc_class] + 1'b1;
        end else begin
          bus.alloc_ok   <= 1'b0;
          bus.alloc_node <= '0;
        end
      end
      // A clear in the same cycle as an allocation to that class wins.
      if (accept && op == OP_CLEAR && int'(bus.req_class) < NUM_CLASSES)
        count[bus.req_class] <= '0;
    end
  end

  always_comb begin
    bus.node_count = '0;
    for (int c = 0; c < NUM_CLASSES; c++) bus.node_count[c*KW +: KW] = count[c];
  end
endmodule

// File: tb/tb_gam_node_memory.sv
// Directed bench for gam_node_memory: a per-node array model predicts every
// response and allocation result; a negedge process compares them each cycle.
module tb_gam_node_memory;
  localparam int NC  = 8;
  localparam int NPC = 16;
  localparam int KW  = 5;
  localparam logic [1:0] OP_READ = 2'd0, OP_WRITE = 2'd1, OP_INC = 2'd2, OP_CLEAR = 2'd3;

  typedef struct {
    int          due;
    logic        err;
    logic [63:0] x;
    logic [63:0] w;
    logic [31:0] th;
    logic [31:0] m;
  } rsp_t;

  typedef struct {
    int         due;
    logic       ok;
    logic [3:0] node;
  } alloc_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  rsp_t   rq[$];
  alloc_t aq[$];

  logic [63:0] mx [NC][NPC];
  logic [63:0] mw [NC][NPC];
  logic [31:0] mth[NC][NPC];
  logic [31:0] mm [NC][NPC];
  int          cnt[NC];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gam_node_memory_if bus();
  gam_node_memory dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : cmp
    rsp_t   r;
    alloc_t a;
    if (rst_n === 1'b1) begin
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        check("rsp_valid", bus.rsp_valid, 1'b1);
        check("rsp_err",   bus.rsp_err,   r.err);
        check("rsp_x",     bus.rsp_x,     r.x);
        check("rsp_w",     bus.rsp_w,     r.w);
        check("rsp_th",    bus.rsp_th,    r.th);
        check("rsp_m",     bus.rsp_m,     r.m);
      end else begin
        check("rsp_idle", bus.rsp_valid, 1'b0);
      end
      if (aq.size() > 0 && aq[0].due == cyc) begin
        a = aq.pop_front();
        check("alloc_done", bus.alloc_done, 1'b1);
        check("alloc_ok",   bus.alloc_ok,   a.ok);
        check("alloc_node", bus.alloc_node, a.node);
      end else begin
        check("alloc_idle", bus.alloc_done, 1'b0);
      end
    end
  end

  // One cycle of stimulus; the model applies the request against pre-edge counts,
  // then the allocation, then a clear (which overrides a same-class allocation).
  task automatic drive(input bit rv, input logic [1:0] op, input int cls, input int node,
                       input logic [3:0] fen, input logic [63:0] x, input logic [63:0] w,
                       input logic [31:0] th, input logic [31:0] m, input bit av, input int acls);
    rsp_t   r;
    alloc_t a;
    bit     live;
    @(posedge clk); #1;
    bus.req_valid   = rv;
    bus.req_op      = op;
    bus.req_class   = cls[2:0];
    bus.req_node    = node[3:0];
    bus.req_fen     = fen;
    bus.req_x       = x;
    bus.req_w       = w;
    bus.req_th      = th;
    bus.req_m       = m;
    bus.alloc_valid = av;
    bus.alloc_class = acls[2:0];
    if (rv) begin
      live = node < cnt[cls];
      r = '{due: cyc + 1, err: 1'b0, x: '0, w: '0, th: '0, m: '0};
      case (op)
        OP_READ: if (live) begin
          r.x = mx[cls][node]; r.w = mw[cls][node]; r.th = mth[cls][node]; r.m = mm[cls][node];
        end else r.err = 1'b1;
        OP_WRITE: if (live) begin
          if (fen[0]) mx[cls][node]  = x;
          if (fen[1]) mw[cls][node]  = w;
          if (fen[2]) mth[cls][node] = th;
          if (fen[3]) mm[cls][node]  = m;
        end else r.err = 1'b1;
        OP_INC: if (live) begin
          if (mm[cls][node] != 32'hFFFF_FFFF) mm[cls][node] = mm[cls][node] + 1;
          r.m = mm[cls][node];
        end else r.err = 1'b1;
        default: ;
      endcase
      rq.push_back(r);
    end
    if (av) begin
      a.due = cyc + 1;
      if (rv && op == OP_CLEAR && cls == acls) begin
        a.ok = 1'b0; a.node = 4'd0;
      end else if (cnt[acls] < NPC) begin
        a.ok = 1'b1; a.node = 4'(cnt[acls]); cnt[acls]++;
      end else begin
        a.ok = 1'b0; a.node = 4'd0;
      end
      aq.push_back(a);
    end
    if (rv && op == OP_CLEAR) cnt[cls] = 0;
  endtask

  task automatic req(input logic [1:0] op, input int cls, input int node, input logic [3:0] fen,
                     input logic [63:0] x, input logic [63:0] w, input logic [31:0] th,
                     input logic [31:0] m);
    drive(1'b1, op, cls, node, fen, x, w, th, m, 1'b0, 0);
  endtask

  task automatic rd(input int cls, input int node);
    req(OP_READ, cls, node, 4'h0, '0, '0, '0, '0);
  endtask

  task automatic alloc(input int cls);
    drive(1'b0, OP_READ, 0, 0, 4'h0, '0, '0, '0, '0, 1'b1, cls);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.req_valid   = 1'b0;
      bus.alloc_valid = 1'b0;
    end
  endtask

  task automatic apply_reset(input int hold);
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_class = '0; bus.req_node = '0;
    bus.req_fen = '0; bus.req_x = '0; bus.req_w = '0; bus.req_th = '0; bus.req_m = '0;
    bus.alloc_valid = 1'b0; bus.alloc_class = '0;
    rq.delete();
    aq.delete();
    for (int c = 0; c < NC; c++) begin
      cnt[c] = 0;
      for (int n = 0; n < NPC; n++) begin
        mx[c][n] = '0; mw[c][n] = '0; mth[c][n] = '0; mm[c][n] = '0;
      end
    end
    #1;
    check("rst_req_ready",  bus.req_ready,  1'b0);
    check("rst_rsp_valid",  bus.rsp_valid,  1'b0);
    check("rst_rsp_err",    bus.rsp_err,    1'b0);
    check("rst_rsp_x",      bus.rsp_x,      64'h0);
    check("rst_rsp_m",      bus.rsp_m,      32'h0);
    check("rst_alloc_done", bus.alloc_done, 1'b0);
    check("rst_alloc_ok",   bus.alloc_ok,   1'b0);
    check("rst_node_count", bus.node_count, 40'h0);
    repeat (hold) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_init();
    int zeros = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) break;
      zeros++;
    end
    check("init_cycles", zeros, 128);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    #3;
    apply_reset(3);
    wait_init();

    // Unallocated node after reset reads as error with zero data.
    rd(3, 0); idle(1); @(negedge clk);
    check("lit_unalloc_err", bus.rsp_err, 1'b1);
    check("lit_unalloc_x",   bus.rsp_x,   64'h0);

    alloc(2); idle(1); @(negedge clk);
    check("lit_alloc_node", bus.alloc_node, 4'd0);
    check("lit_alloc_ok",   bus.alloc_ok,   1'b1);

    // Write then read back to back.
    req(OP_WRITE, 2, 0, 4'hF, {4{16'h1234}}, {4{16'h1234}}, 32'd100, 32'd5);
    rd(2, 0); idle(1); @(negedge clk);
    check("lit_rd_x",   bus.rsp_x,  64'h1234_1234_1234_1234);
    check("lit_rd_th",  bus.rsp_th, 32'd100);
    check("lit_rd_m",   bus.rsp_m,  32'd5);
    check("lit_cnt2",   bus.node_count[2*KW +: KW], 5'd1);

    // Partial write of Th only.
    req(OP_WRITE, 2, 0, 4'b0100, 64'hDEAD, 64'hBEEF, 32'd7, 32'd99);
    rd(2, 0); idle(1); @(negedge clk);
    check("lit_pw_th", bus.rsp_th, 32'd7);
    check("lit_pw_m",  bus.rsp_m,  32'd5);
    check("lit_pw_w",  bus.rsp_w,  64'h1234_1234_1234_1234);

    // Fill class 1, then one more allocation is refused.
    for (int i = 0; i < 17; i++) alloc(1);
    idle(1); @(negedge clk);
    check("lit_full_ok",   bus.alloc_ok,   1'b0);
    check("lit_full_node", bus.alloc_node, 4'd0);
    check("lit_cnt1_full", bus.node_count[1*KW +: KW], 5'd16);
    req(OP_WRITE, 1, 0, 4'hF, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 32'd9, 32'd3);
    req(OP_INC, 1, 3, 4'h0, '0, '0, '0, '0);
    req(OP_WRITE, 1, 15, 4'h2, '0, 64'h0F0F, '0, '0);
    rd(1, 15);

    // Saturating INC_M.
    req(OP_WRITE, 2, 0, 4'b1000, '0, '0, '0, 32'hFFFF_FFFE);
    req(OP_INC, 2, 0, 4'h0, '0, '0, '0, '0);
    req(OP_INC, 2, 0, 4'h0, '0, '0, '0, '0);
    idle(1); @(negedge clk);
    check("lit_sat_m", bus.rsp_m, 32'hFFFF_FFFF);

    // Same-cycle allocation and request to the slot being granted.
    req(OP_WRITE, 2, 1, 4'hF, 64'h1, 64'h1, 32'd1, 32'd1);
    drive(1'b1, OP_READ, 2, 1, 4'h0, '0, '0, '0, '0, 1'b1, 2);
    idle(1); @(negedge clk);
    check("lit_race_err",  bus.rsp_err,    1'b1);
    check("lit_race_node", bus.alloc_node, 4'd1);
    rd(2, 1);

    // Clear wins over a same-cycle allocation; data survives for re-allocation.
    drive(1'b1, OP_CLEAR, 1, 5, 4'h0, '0, '0, '0, '0, 1'b1, 1);
    idle(1); @(negedge clk);
    check("lit_clr_ok",  bus.alloc_ok,  1'b0);
    check("lit_clr_err", bus.rsp_err,   1'b0);
    check("lit_clr_cnt", bus.node_count[1*KW +: KW], 5'd0);
    rd(1, 0);
    alloc(1);
    rd(1, 0); idle(1); @(negedge clk);
    check("lit_stale_x", bus.rsp_x, 64'hAAAA_AAAA_AAAA_AAAA);

    // Reset while a response is in flight drops it at once.
    rd(2, 0);
    @(posedge clk); #2;
    check("lit_inflight", bus.rsp_valid, 1'b1);
    apply_reset(2);
    repeat (50) @(posedge clk);
    #1;
    apply_reset(2);
    wait_init();

    // The sweep zeroed previously written data.
    alloc(2);
    rd(2, 0); idle(1); @(negedge clk);
    check("lit_swept_x", bus.rsp_x, 64'h0);
    check("lit_swept_m", bus.rsp_m, 32'h0);
    idle(3);
    check("queue_drain", rq.size() + aq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
